rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes.
//   Arbitrates among requesting input channels using round-robin or fixed priority.
//   Registers the winner's data and index into a one-entry output stage.
//   Successor to the combinational 8x1 select mux, for channel merging on shared datapaths.
// PARAMETERS
//   NUM_CH  8  number of input channels (>=2)
//   DATA_W  4  data width per channel
//   CH_W    $clog2(NUM_CH)  index width (derived; not overridden)
// PORTS
//   clk        in   1               clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   prio_mode  in   1               0 = round-robin, 1 = fixed priority (lowest index wins)
//   ch_en      in   NUM_CH          per-channel enable mask; a disabled channel never wins
//   in_valid   in   NUM_CH          per-channel request
//   in_data    in   NUM_CH*DATA_W   packed data; channel i is in bits [i*DATA_W +: DATA_W]
//   in_ready   out  NUM_CH          one-hot grant, high only for the accepted channel
//   out_valid  out  1               output register holds data
//   out_data   out  DATA_W          registered winner data
//   out_ch     out  CH_W            registered winner index
//   out_ready  in   1               downstream accepts when out_valid & out_ready
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//     in_ready is 0 while in reset.
//   - req = in_valid & ch_en.
//   - Acceptance window: can_load = !out_valid | out_ready.
//   - Grant:
//     - When can_load and req is nonzero, exactly one bit of in_ready is high, at the winner g.
//       in_ready is combinational from req, rr_ptr, prio_mode and out_ready.
//     - Otherwise in_ready is all zeros.
//   - Round-robin (prio_mode=0):
//     - g is the first set bit of req searching upward from rr_ptr, wrapping NUM_CH-1 -> 0.
//     - On a grant, rr_ptr <= (g==NUM_CH-1) ? 0 : g+1.
//   - Fixed (prio_mode=1): g is the lowest set bit of req. rr_ptr is held unchanged.
//   - Transfer:
//     - On a grant edge: out_valid<=1, out_data<=in_data[g], out_ch<=g.
//     - Latency is 1 cycle from the input handshake to out_valid.
//   - Drain: out_valid & out_ready with no new grant -> out_valid<=0.
//     out_data and out_ch hold their last values.
//   - Simultaneous drain and load: the new word replaces the old in the same cycle, with no bubble.
//     Sustained throughput is 1 word per clk.
//   - Stall: out_valid & !out_ready:
//     - in_ready=0; out_data, out_ch and rr_ptr are frozen.
//     - Inputs must hold in_valid and in_data (standard valid/ready).
//   - prio_mode or ch_en changes take effect combinationally on the next grant decision.
//     No state is flushed.
//   - Single requester: granted every cycle that can_load is true, in either mode.
//   - Reset asserted mid-transfer: the word in the output register is discarded.
//     Arbitration restarts from channel 0.
// STRUCTURE
//   - Shared package arb_pkg holds:
//     - clog2 helper function;
//     - PRIO_RR / PRIO_FIXED mode constants.
//   - Sub-module rr_pick (NUM_CH):
//     - inputs: req, start_ptr;
//     - outputs: one-hot gnt, binary gnt_idx, any;
//     - fixed mode is start_ptr=0;
//     - built as a double-width rotate and priority encode.
//   - Top level:
//     - mask logic;
//     - rr_pick instance;
//     - data select loop over channels;
//     - output register;
//     - rr_ptr register.
// TESTING  (NUM_CH=8, DATA_W=4, ch i data = 8+i, i.e. 8..15)
//   1. Reset: rst_n=0 with all in_valid=1, then release.
//      -> Outputs stay 0 and in_ready=0 during reset. First grant is ch0; out_data=8 one clk later.
//   2. RR fairness: all 8 valid, ch_en=8'hFF, out_ready=1.
//      -> out_ch goes 0,1,...,7,0 and out_data goes 8..15,8, one word per clk, no bubbles.
//   3. Fixed priority: prio_mode=1, in_valid=8'b1010_0100, out_ready=1.
//      -> out_ch=2 every cycle; ch5 and ch7 starve. rr_ptr is unchanged afterwards.
//   4. Backpressure: out_ready=0 for 3 clks after a load of ch3.
//      -> out_data=11 and out_ch=3 held, in_ready=0. On out_ready=1 the next grant is ch4.
//   5. Mask and wrap: rr_ptr=7, ch_en=8'b0111_1111, in_valid=8'hFF.
//      -> ch7 skipped; grant wraps to ch0 and rr_ptr becomes 1.
//   6. Async reset mid-stream: pull rst_n low between clk edges while out_valid=1.
//      -> out_valid falls immediately without waiting for clk. After release, arbitration resumes at ch0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: mode encodings and a constant-width helper.
// Imported by rr_pick and rr_arb_mux.
package arb_pkg;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set bit of req at or above start_ptr.
// Uses a double-width rotate followed by a lowest-bit priority encode.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   start_ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W-1:0]     off;
  logic [CH_W:0]       sum;

  assign dbl = {req, req} >> start_ptr;
  assign rot = dbl[NUM_CH-1:0];
  assign any = |req;

  always_comb begin
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
  end

  // Undo the rotation, wrapping modulo NUM_CH.
  always_comb begin
    sum = {1'b0, start_ptr} + {1'b0, off};
    if (sum >= (CH_W+1)'(NUM_CH)) begin
      sum = sum - (CH_W+1)'(NUM_CH);
    end
    gnt_idx = sum[CH_W-1:0];
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = any && (gnt_idx == CH_W'(i));
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel registered mux with round-robin / fixed-priority arbitration.
// One-entry output stage, valid/ready on both sides, 1 word per clk.
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 4,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prio_mode,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   start;
  logic [CH_W-1:0]   rr_ptr;
  logic [DATA_W-1:0] sel;
  logic              any;
  logic              can_load;
  logic              grant;

  assign req      = in_valid & ch_en;
  assign can_load = !out_valid || out_ready;
  assign start    = (prio_mode == PRIO_FIXED) ? '0 : rr_ptr;
  assign grant    = can_load && any;
  assign in_ready = (grant && rst_n) ? gnt : '0;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req       (req),
    .start_ptr (start),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any       (any)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) sel = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= sel;
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Fixed mode leaves the round-robin position untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant && prio_mode == PRIO_RR) begin
      if (gnt_idx == CH_W'(NUM_CH - 1)) rr_ptr <= '0;
      else                              rr_ptr <= gnt_idx + CH_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: reference arbiter model plus
// a scoreboard queue of expected {ch, data} words.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic        prio_mode;
  logic [7:0]  ch_en;
  logic [7:0]  in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_ready;

  int n_chk;
  int n_fail;

  logic [6:0] sb[$];
  int         mptr;
  logic       mvalid;
  logic [2:0] mch;
  logic [3:0] mdata;

  rr_arb_mux #(
    .NUM_CH (8),
    .DATA_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .ch_en     (ch_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mptr   = 0;
    mvalid = 1'b0;
    mch    = '0;
    mdata  = '0;
    sb.delete();
  endtask

  // Called at a negedge with inputs already applied.
  task automatic step();
    logic [7:0] req;
    logic [7:0] exp_rdy;
    logic [6:0] e;
    int         g;
    int         st;
    int         c;
    #1;
    req = in_valid & ch_en;
    g   = -1;
    if (!mvalid || out_ready) begin
      st = prio_mode ? 0 : mptr;
      for (int k = 0; k < 8; k++) begin
        c = (st + k) % 8;
        if (g < 0 && req[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? 8'(1 << g) : 8'h00;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (g >= 0) begin
      sb.push_back({g[2:0], 4'(8 + g)});
      if (!prio_mode) mptr = (g == 7) ? 0 : g + 1;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      e      = sb.pop_front();
      mvalid = 1'b1;
      mch    = e[6:4];
      mdata  = e[3:0];
      chk("out_ch", 32'(out_ch), 32'(e[6:4]));
      chk("out_data", 32'(out_data), 32'(e[3:0]));
    end else begin
      if (mvalid && out_ready) mvalid = 1'b0;
      if (mvalid) begin
        chk("held_ch", 32'(out_ch), 32'(mch));
        chk("held_data", 32'(out_data), 32'(mdata));
      end
    end
    chk("out_valid", 32'(out_valid), 32'(mvalid));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 8'hFF;
    model_reset();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'h0);
    chk("rst_hold_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    prio_mode = 1'b0;
    ch_en     = 8'hFF;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*4 +: 4] = 4'(8 + i);
    model_reset();

    // 1: reset with all requesting, first grant ch0
    do_reset();
    step();

    // 2: round-robin fairness, 0..7,0 back to back
    do_reset();
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) step();

    // 3: fixed priority starves ch5/ch7, then rr resumes at held ptr
    do_reset();
    in_valid = 8'hFF;
    step();
    step();
    prio_mode = 1'b1;
    in_valid  = 8'b1010_0100;
    for (int i = 0; i < 5; i++) step();
    prio_mode = 1'b0;
    in_valid  = 8'hFF;
    step();
    step();

    // 4: backpressure after a ch3 load
    do_reset();
    in_valid = 8'b0000_1000;
    step();
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();
    step();

    // 5: mask ch7 at ptr 7, wrap to ch0, ptr 1
    do_reset();
    in_valid = 8'b0100_0000;
    step();
    ch_en    = 8'b0111_1111;
    in_valid = 8'hFF;
    step();
    step();
    ch_en = 8'hFF;
    in_valid = 8'h00;
    step();
    step();

    // 6: async reset between edges while out_valid is high
    do_reset();
    in_valid = 8'hFF;
    step();
    step();
    @(posedge clk);
    #3;
    chk("pre_async_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_ready", 32'(in_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
